// File: rtl/vram_arbiter.sv
// Arbitrates bg/obj/cpu fetch ports onto one VRAM BRAM (priority obj > bg > cpu); uncontested response READ_LATENCY+2 edges after capture.
// Backpressure: one outstanding request per port, busy_out high from capture until the response pulse; valid is ignored while busy.
module vram_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  ppu_mode_in,
    input  logic [15:0] bg_addr_in,
    input  logic        bg_valid_in,
    output logic [7:0]  bg_data_out,
    output logic        bg_data_valid_out,
    output logic        bg_busy_out,
    input  logic [15:0] obj_addr_in,
    input  logic        obj_valid_in,
    output logic [7:0]  obj_data_out,
    output logic        obj_data_valid_out,
    output logic        obj_busy_out,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_valid_in,
    input  logic        cpu_we_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_valid_out,
    output logic        cpu_busy_out,
    output logic [12:0] vram_addr_out,
    output logic        vram_en_out,
    output logic        vram_we_out,
    output logic [7:0]  vram_wdata_out,
    input  logic [7:0]  vram_rdata_in
);
    localparam int RL = READ_LATENCY;
    localparam logic [1:0] ID_BG  = 2'd0;
    localparam logic [1:0] ID_OBJ = 2'd1;
    localparam logic [1:0] ID_CPU = 2'd2;

    logic [2:0]        pend_q, pend_d, oor_q, oor_d, busy_q, busy_d;
    logic [2:0]        dvld_q, dvld_d, byp_q, byp_d;
    logic [2:0][12:0]  addr_q, addr_d;
    logic [2:0][7:0]   data_q, data_d, byp_dat_q, byp_dat_d;
    logic              cpu_we_q, cpu_we_d;
    logic [7:0]        cpu_wdata_q, cpu_wdata_d;
    logic [RL:0]       tag_vld_q, tag_vld_d, tag_we_q, tag_we_d;
    logic [RL:0][1:0]  tag_id_q, tag_id_d;
    logic              vram_en_q, vram_en_d, vram_we_q, vram_we_d;
    logic [12:0]       vram_addr_q, vram_addr_d;
    logic [7:0]        vram_wdata_q, vram_wdata_d;
    logic [2:0]        req_vld;
    logic [2:0][15:0]  req_addr;
    logic              grant;
    logic [1:0]        gnt_id;

    assign req_vld  = {cpu_valid_in, obj_valid_in, bg_valid_in};
    assign req_addr = {cpu_addr_in, obj_addr_in, bg_addr_in};

    always_comb begin
        pend_d       = pend_q;
        oor_d        = oor_q;
        busy_d       = busy_q;
        addr_d       = addr_q;
        data_d       = data_q;
        dvld_d       = '0;
        byp_d        = '0;
        byp_dat_d    = byp_dat_q;
        cpu_we_d     = cpu_we_q;
        cpu_wdata_d  = cpu_wdata_q;
        tag_vld_d    = {tag_vld_q[RL-1:0], 1'b0};
        tag_we_d     = {tag_we_q[RL-1:0], 1'b0};
        tag_id_d     = {tag_id_q[RL-1:0], 2'b00};
        vram_en_d    = 1'b0;
        vram_we_d    = 1'b0;
        vram_addr_d  = '0;
        vram_wdata_d = '0;
        grant        = 1'b0;
        gnt_id       = ID_BG;

        if (tag_vld_q[RL]) begin
            dvld_d[tag_id_q[RL]] = 1'b1;
            busy_d[tag_id_q[RL]] = 1'b0;
            data_d[tag_id_q[RL]] = tag_we_q[RL] ? 8'h00 : vram_rdata_in;
        end

        // Bypassed responses (out-of-range or blocked CPU) land one edge after resolution.
        for (int r = 0; r < 3; r++) begin
            if (byp_q[r]) begin
                dvld_d[r] = 1'b1;
                busy_d[r] = 1'b0;
                data_d[r] = byp_dat_q[r];
            end
            if (pend_q[r] && oor_q[r]) begin
                pend_d[r]    = 1'b0;
                byp_d[r]     = 1'b1;
                byp_dat_d[r] = 8'hFF;
            end
        end

        if (pend_q[ID_OBJ] && !oor_q[ID_OBJ]) begin
            grant  = 1'b1;
            gnt_id = ID_OBJ;
        end else if (pend_q[ID_BG] && !oor_q[ID_BG]) begin
            grant  = 1'b1;
            gnt_id = ID_BG;
        end else if (pend_q[ID_CPU] && !oor_q[ID_CPU]) begin
            pend_d[ID_CPU] = 1'b0;
            if (ppu_mode_in == 2'd3) begin
                byp_d[ID_CPU]     = 1'b1;
                byp_dat_d[ID_CPU] = cpu_we_q ? 8'h00 : 8'hFF;
            end else begin
                grant  = 1'b1;
                gnt_id = ID_CPU;
            end
        end

        if (grant) begin
            pend_d[gnt_id] = 1'b0;
            vram_en_d      = 1'b1;
            vram_addr_d    = addr_q[gnt_id];
            vram_we_d      = (gnt_id == ID_CPU) && cpu_we_q;
            vram_wdata_d   = vram_we_d ? cpu_wdata_q : 8'h00;
            tag_vld_d[0]   = 1'b1;
            tag_id_d[0]    = gnt_id;
            tag_we_d[0]    = vram_we_d;
        end

        for (int r = 0; r < 3; r++) begin
            if (req_vld[r] && !busy_q[r]) begin
                pend_d[r] = 1'b1;
                busy_d[r] = 1'b1;
                addr_d[r] = req_addr[r][12:0];
                oor_d[r]  = (req_addr[r][15:13] != 3'b100);
            end
        end
        if (cpu_valid_in && !busy_q[ID_CPU]) begin
            cpu_we_d    = cpu_we_in;
            cpu_wdata_d = cpu_wdata_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pend_q       <= '0;
            oor_q        <= '0;
            busy_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            dvld_q       <= '0;
            byp_q        <= '0;
            byp_dat_q    <= '0;
            cpu_we_q     <= 1'b0;
            cpu_wdata_q  <= '0;
            tag_vld_q    <= '0;
            tag_we_q     <= '0;
            tag_id_q     <= '0;
            vram_en_q    <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
        end else begin
            pend_q       <= pend_d;
            oor_q        <= oor_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            dvld_q       <= dvld_d;
            byp_q        <= byp_d;
            byp_dat_q    <= byp_dat_d;
            cpu_we_q     <= cpu_we_d;
            cpu_wdata_q  <= cpu_wdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_we_q     <= tag_we_d;
            tag_id_q     <= tag_id_d;
            vram_en_q    <= vram_en_d;
            vram_we_q    <= vram_we_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
        end
    end

    assign bg_data_out        = data_q[ID_BG];
    assign bg_data_valid_out  = dvld_q[ID_BG];
    assign bg_busy_out        = busy_q[ID_BG];
    assign obj_data_out       = data_q[ID_OBJ];
    assign obj_data_valid_out = dvld_q[ID_OBJ];
    assign obj_busy_out       = busy_q[ID_OBJ];
    assign cpu_data_out       = data_q[ID_CPU];
    assign cpu_data_valid_out = dvld_q[ID_CPU];
    assign cpu_busy_out       = busy_q[ID_CPU];
    assign vram_addr_out      = vram_addr_q;
    assign vram_en_out        = vram_en_q;
    assign vram_we_out        = vram_we_q;
    assign vram_wdata_out     = vram_wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency VRAM model.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [15:0] bg_addr = '0, obj_addr = '0, cpu_addr = '0;
    logic        bg_valid = 1'b0, obj_valid = 1'b0, cpu_valid = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  bg_data_out, obj_data_out, cpu_data_out;
    logic        bg_data_valid_out, obj_data_valid_out, cpu_data_valid_out;
    logic        bg_busy_out, obj_busy_out, cpu_busy_out;
    logic [12:0] vram_addr_out;
    logic        vram_en_out, vram_we_out;
    logic [7:0]  vram_wdata_out;
    logic [7:0]  vram_rdata = '0;
    logic [7:0]  mem [8192];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cnt;

    always #5 clk = ~clk;

    vram_arbiter #(.READ_LATENCY(1)) dut (
        .clk_in(clk), .rst_in(rst), .ppu_mode_in(mode),
        .bg_addr_in(bg_addr), .bg_valid_in(bg_valid), .bg_data_out(bg_data_out),
        .bg_data_valid_out(bg_data_valid_out), .bg_busy_out(bg_busy_out),
        .obj_addr_in(obj_addr), .obj_valid_in(obj_valid), .obj_data_out(obj_data_out),
        .obj_data_valid_out(obj_data_valid_out), .obj_busy_out(obj_busy_out),
        .cpu_addr_in(cpu_addr), .cpu_valid_in(cpu_valid), .cpu_we_in(cpu_we),
        .cpu_wdata_in(cpu_wdata), .cpu_data_out(cpu_data_out),
        .cpu_data_valid_out(cpu_data_valid_out), .cpu_busy_out(cpu_busy_out),
        .vram_addr_out(vram_addr_out), .vram_en_out(vram_en_out), .vram_we_out(vram_we_out),
        .vram_wdata_out(vram_wdata_out), .vram_rdata_in(vram_rdata)
    );

    // VRAM model: rdata valid the cycle after the enable cycle; contents reloaded while reset is high.
    always @(posedge clk) begin
        if (rst) begin
            mem[13'h1800] <= 8'h3C;
            mem[13'h0010] <= 8'h11;
            mem[13'h0020] <= 8'h22;
            mem[13'h0030] <= 8'h33;
            mem[13'h0000] <= 8'h00;
            vram_rdata    <= 8'h00;
        end else if (vram_en_out) begin
            if (vram_we_out) mem[vram_addr_out] <= vram_wdata_out;
            vram_rdata <= mem[vram_addr_out];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bg"}, {5'd0, bg_busy_out, bg_data_valid_out, 1'b0, bg_data_out}, 16'h0);
        chk({tag, "_obj"}, {5'd0, obj_busy_out, obj_data_valid_out, 1'b0, obj_data_out}, 16'h0);
        chk({tag, "_cpu"}, {5'd0, cpu_busy_out, cpu_data_valid_out, 1'b0, cpu_data_out}, 16'h0);
        chk({tag, "_vram"}, {vram_en_out, vram_we_out, 1'b0, vram_addr_out}, 16'h0);
        chk({tag, "_wdata"}, {8'd0, vram_wdata_out}, 16'h0);
    endtask

    initial begin
        tick;
        tick;
        chk_all_zero("reset");

        // Uncontested bg read at 9800, captured on the first edge after reset release
        rst = 1'b0; bg_addr = 16'h9800; bg_valid = 1'b1;
        tick;                                   // E0
        bg_valid = 1'b0;
        chk("bg_e0_busy", {15'd0, bg_busy_out}, 16'd1);
        chk("bg_e0_en", {15'd0, vram_en_out}, 16'd0);
        tick;                                   // E1
        chk("bg_e1_en", {15'd0, vram_en_out}, 16'd1);
        chk("bg_e1_addr", {3'd0, vram_addr_out}, 16'h1800);
        chk("bg_e1_we", {15'd0, vram_we_out}, 16'd0);
        tick;                                   // E2
        chk("bg_e2_en", {15'd0, vram_en_out}, 16'd0);
        chk("bg_e2_vld_busy", {14'd0, bg_data_valid_out, bg_busy_out}, 16'b01);
        tick;                                   // E3
        chk("bg_e3_vld_busy", {14'd0, bg_data_valid_out, bg_busy_out}, 16'b10);
        chk("bg_e3_data", {8'd0, bg_data_out}, 16'h003C);
        tick;
        chk("bg_e4_vld", {15'd0, bg_data_valid_out}, 16'd0);

        // obj, bg and cpu read all captured on the same edge
        obj_addr = 16'h8010; bg_addr = 16'h8020; cpu_addr = 16'h8030; cpu_we = 1'b0;
        obj_valid = 1'b1; bg_valid = 1'b1; cpu_valid = 1'b1;
        tick;                                   // E0
        obj_valid = 1'b0; bg_valid = 1'b0; cpu_valid = 1'b0;
        chk("pri_e0_busy", {13'd0, cpu_busy_out, obj_busy_out, bg_busy_out}, 16'b111);
        tick;                                   // E1
        chk("pri_e1", {vram_en_out, 2'd0, vram_addr_out}, 16'h8010);
        tick;                                   // E2
        chk("pri_e2", {vram_en_out, 2'd0, vram_addr_out}, 16'h8020);
        tick;                                   // E3
        chk("pri_e3", {vram_en_out, 2'd0, vram_addr_out}, 16'h8030);
        chk("pri_e3_obj", {7'd0, obj_data_valid_out, obj_data_out}, 16'h0111);
        chk("pri_e3_others", {14'd0, bg_data_valid_out, cpu_data_valid_out}, 16'd0);
        tick;                                   // E4
        chk("pri_e4_bg", {7'd0, bg_data_valid_out, bg_data_out}, 16'h0122);
        chk("pri_e4_en", {15'd0, vram_en_out}, 16'd0);
        tick;                                   // E5
        chk("pri_e5_cpu", {7'd0, cpu_data_valid_out, cpu_data_out}, 16'h0133);
        chk("pri_e5_busy", {13'd0, cpu_busy_out, obj_busy_out, bg_busy_out}, 16'd0);

        // CPU write blocked during drawing mode
        mode = 2'd3; cpu_addr = 16'h8000; cpu_we = 1'b1; cpu_wdata = 8'hAA; cpu_valid = 1'b1;
        tick;                                   // E0
        cpu_valid = 1'b0;
        tick;                                   // E1
        chk("blk_e1", {14'd0, vram_en_out, cpu_data_valid_out}, 16'd0);
        tick;                                   // E2
        chk("blk_e2_cpu", {7'd0, cpu_data_valid_out, cpu_data_out}, 16'h0100);
        chk("blk_e2_en", {14'd0, vram_en_out, cpu_busy_out}, 16'd0);
        tick;
        chk("blk_mem0", {8'd0, mem[0]}, 16'h0000);

        // Same write in VBlank goes through
        mode = 2'd1; cpu_valid = 1'b1;
        tick;                                   // E0
        cpu_valid = 1'b0;
        tick;                                   // E1
        chk("wr_e1", {vram_en_out, vram_we_out, 1'b0, vram_addr_out}, 16'hC000);
        chk("wr_e1_wdata", {8'd0, vram_wdata_out}, 16'h00AA);
        tick;                                   // E2
        chk("wr_e2_vld", {15'd0, cpu_data_valid_out}, 16'd0);
        tick;                                   // E3
        chk("wr_e3_cpu", {7'd0, cpu_data_valid_out, cpu_data_out}, 16'h0100);
        chk("wr_mem0", {8'd0, mem[0]}, 16'h00AA);
        cpu_we = 1'b0; mode = 2'd0;

        // Out-of-range bg address never reaches VRAM
        bg_addr = 16'hC000; bg_valid = 1'b1;
        tick;                                   // E0
        bg_valid = 1'b0;
        tick;                                   // E1
        chk("oor_e1", {14'd0, vram_en_out, bg_data_valid_out}, 16'd0);
        tick;                                   // E2
        chk("oor_e2_bg", {7'd0, bg_data_valid_out, bg_data_out}, 16'h01FF);
        chk("oor_e2_en_busy", {14'd0, vram_en_out, bg_busy_out}, 16'd0);

        // bg valid held for three edges: only the first is captured
        bg_addr = 16'h9800;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            bg_valid = (i < 3);
            tick;
            if (bg_data_valid_out) cnt++;
        end
        chk("busy_ignore_count", cnt[15:0], 16'd1);
        chk("busy_ignore_data", {8'd0, bg_data_out}, 16'h003C);

        // Reset between grant and response drops the access
        bg_valid = 1'b1;
        tick;                                   // E0
        bg_valid = 1'b0;
        tick;                                   // E1 grant
        chk("rst_grant_en", {15'd0, vram_en_out}, 16'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bg_data_valid_out || obj_data_valid_out || cpu_data_valid_out || vram_en_out) cnt++;
        end
        chk("rst_no_response", cnt[15:0], 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1, VRAM read latency in cycles from an enable cycle to rdata valid; legal range 1..3.
REQ-002 clk_in  input  1  system clock, all state on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 ppu_mode_in  input  2  PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 drawing).
REQ-005 bg_addr_in 16 in, bg_valid_in 1 in, bg_data_out 8 out, bg_data_valid_out 1 out, bg_busy_out 1 out: background fetcher port.
REQ-006 obj_addr_in 16 in, obj_valid_in 1 in, obj_data_out 8 out, obj_data_valid_out 1 out, obj_busy_out 1 out: sprite fetcher port.
REQ-007 cpu_addr_in 16 in, cpu_valid_in 1 in, cpu_we_in 1 in, cpu_wdata_in 8 in, cpu_data_out 8 out, cpu_data_valid_out 1 out, cpu_busy_out 1 out: CPU port.
REQ-008 vram_addr_out 13 out, vram_en_out 1 out, vram_we_out 1 out, vram_wdata_out 8 out, vram_rdata_in 8 in: single-port VRAM BRAM.

Function
REQ-009 A requester's valid, sampled high at edge E0 while its busy_out is low, SHALL capture addr (and CPU we/wdata) into that requester's pending slot and raise busy_out from E0.
REQ-010 Valid sampled while busy_out is high SHALL be ignored; at most one outstanding request per requester.
REQ-011 busy_out SHALL fall on the same edge that asserts that requester's data_valid_out.
REQ-012 Each edge the arbiter SHALL grant at most one eligible pending slot, priority obj > bg > cpu, and clear that slot.
REQ-013 A slot captured at E0 SHALL be eligible no earlier than edge E1.
REQ-014 A grant at edge E SHALL register vram_en_out=1, vram_addr_out=addr[12:0], vram_we_out/vram_wdata_out (CPU write only, else 0) for exactly one cycle.
REQ-015 A granted access SHALL travel a READ_LATENCY+1 stage tag pipeline {requester id, write flag}.
REQ-016 On exit from the tag pipeline the tagged port SHALL register data_out=vram_rdata_in (CPU write: 8'h00) and pulse data_valid_out for one cycle.
REQ-017 Uncontested latency SHALL be exactly READ_LATENCY+2 edges from E0 to data_valid_out.
REQ-018 Addresses outside 16'h8000..16'h9FFF SHALL NOT access VRAM: data_out=8'hFF, data_valid_out pulses at E0+2, no grant slot consumed.
REQ-019 CPU slot when ppu_mode_in==3 at its would-be grant edge SHALL be blocked: no VRAM access, writes discarded, data_out=8'hFF (write: 8'h00), data_valid_out at that edge+1.
REQ-020 CPU requests SHALL be granted normally in modes 0, 1, 2; mode changes SHALL NOT affect already-granted accesses.
REQ-021 Simultaneous pending obj and bg at the same edge: obj granted first, bg next edge; CPU waits until both slots empty.
REQ-022 Responses for different requesters on the same edge SHALL all be delivered on their own ports; none dropped.
REQ-023 vram_en_out SHALL be low on every edge with no grant; at most one VRAM access per cycle.

Reset
REQ-024 While rst_in is high: all pending slots and tag pipeline cleared; every output 0 (data_out 8'h00, valid/busy/en/we low).
REQ-025 Reset mid-operation SHALL drop in-flight accesses; no data_valid_out pulse for any request captured before reset deassertion.
REQ-026 First valid is sampled on the first rising edge after rst_in deasserts.

Verification
REQ-027 READ_LATENCY=1, mode 0, bg_valid addr 16'h9800 with VRAM[0x1800]=8'h3C -> vram_en at E1 addr 13'h1800, bg_data_out=8'h3C valid at E3, bg_busy E0..E3.
REQ-028 obj addr 16'h8010 and bg addr 16'h8020 valid same edge, cpu read pending -> VRAM addrs 0x0010, 0x0020, then cpu in consecutive cycles; responses in that order.
REQ-029 Mode 3, cpu write 16'h8000 data 8'hAA -> no vram_en, cpu_data_valid_out with 8'h00 at E2, VRAM[0] unchanged; repeat in mode 1 -> VRAM[0]=8'hAA.
REQ-030 bg_valid addr 16'hC000 -> bg_data_out=8'hFF valid at E2, vram_en never asserted.
REQ-031 Second bg_valid while bg_busy_out high -> ignored, exactly one response; rst_in pulsed between grant and response -> no response, all outputs 0.
